csoc_scan_ctrl: RTL and testbench
=================================

Name: csoc_scan_ctrl

Overview:
- Command engine between the board UART receiver/transmitter and the CSoC test pins.
- Consumes received bytes (rcv strobe + data) as a command stream. Drives CSoC reset, test mode, scan enable, scan clock and 8 parallel scan-in bits.
- Returns scan-out bytes and acknowledges through a start/ready handshake to the UART transmitter.

Parameters:
- CLK_DIV, 4, system clocks per csoc_clk phase (low/setup phase and high phase); legal 1..255.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- rx_rcv  input  1  one-cycle strobe, rx_data valid
- rx_data  input  8  received byte
- tx_ready  input  1  transmitter idle, may accept tx_start
- tx_start  output  1  one-cycle strobe, tx_data valid
- tx_data  output  8  byte to transmit
- csoc_reset  output  1  CSoC reset level
- csoc_test_tm  output  1  CSoC test mode
- csoc_test_se  output  1  scan enable
- csoc_clk  output  1  generated CSoC clock
- csoc_data_o  output  8  scan-in bits, one per chain
- csoc_data_i  input  8  scan-out bits, one per chain
- overrun  output  1  sticky: a byte was dropped

Behaviour:
- Reset (rst high at a clk edge) sets the following values:
  - csoc_reset=1
  - csoc_test_tm=0, csoc_test_se=0, csoc_clk=0
  - csoc_data_o=0, tx_start=0, tx_data=0, overrun=0
  - state=IDLE; counters cleared
- Reset mid-operation aborts any command immediately. No reply is sent.
- Commands (first byte in IDLE):
  - 0x00 NOP: reply 0x00.
  - 0x10 MODE + arg byte: csoc_test_tm=arg[0], csoc_reset=arg[1], applied the cycle after arg received. Reply 0x10.
  - 0x20 SHIFT + count byte N (0 means 256), then N data bytes. Each data byte produces one reply byte = scan-out sample; no separate ack.
  - 0x30 CAPTURE + count byte M (0 means 256): se=0, M csoc_clk pulses. Reply 0x30.
  - 0x40 STATUS: reply {5'b0, overrun, csoc_reset, csoc_test_tm}. Clears overrun in the same cycle tx_start fires.
  - Any other opcode: reply 0xEE, return to IDLE.
- States:
  - IDLE: wait for an opcode.
  - ARG: wait for an arg/count byte.
  - SDATA: wait for a shift data byte.
  - SETUP: csoc_clk=0 for CLK_DIV cycles.
  - HIGH: csoc_clk=1 for CLK_DIV cycles.
  - REPLY: hold until tx_ready, then pulse.
- SHIFT byte timing:
  - On rx_rcv in SDATA: csoc_data_o<=rx_data, csoc_test_se<=1, go to SETUP.
  - csoc_data_i is sampled on the last SETUP cycle, before the rising csoc_clk edge.
  - HIGH then drives csoc_clk=1 for CLK_DIV cycles, then csoc_clk<=0 and go to REPLY with tx_data=sample.
  - After the reply, decrement the remaining count. If zero: se<=0, IDLE; else SDATA.
- CAPTURE: csoc_test_se=0, then M consecutive SETUP/HIGH pairs, then REPLY. The csoc_clk period is 2*CLK_DIV cycles.
- REPLY: tx_data is valid from state entry. tx_start is high for exactly one cycle, the first cycle tx_ready=1. tx_start must never be asserted while tx_ready=0.
- Dropped input:
  - rx_rcv in SETUP, HIGH or REPLY: the byte is discarded, overrun<=1, and state is unaffected.
  - If an overrun set and a STATUS-clear occur in the same cycle, set wins.
- Count arithmetic: 9-bit counter loaded with N==0 ? 256 : N. No wrap.
- csoc_clk is a registered output only. Never a combinational function of clk.

Test Plan:
- Reset, then MODE 0x10,0x03 -> csoc_test_tm=1, csoc_reset=1; tx_start with tx_data=0x10. Then 0x10,0x00 -> tm=0, reset=0, reply 0x10.
- SHIFT 0x20,0x02, data 0xA5 then 0x3C, csoc_data_i=0x5A then 0xC3, CLK_DIV=4:
  - per byte: data_o matches, se=1, 4 low + 4 high csoc_clk cycles
  - replies 0x5A then 0xC3
  - se=0 after the second reply
- CAPTURE 0x30,0x03 -> exactly 3 csoc_clk pulses with se=0; reply 0x30. Also CAPTURE 0x30,0x00 -> 256 pulses.
- tx_ready held low 50 cycles during REPLY -> tx_start stays 0. It pulses once on the first tx_ready=1 cycle, with tx_data stable throughout.
- Byte injected during HIGH of a SHIFT -> overrun=1 and the shift still completes. Then STATUS 0x40 -> reply 0x04 with reset=0, tm=0, and overrun cleared.
- Unknown opcode 0x7F -> reply 0xEE. Assert rst mid-SHIFT (in HIGH) -> all outputs return to reset values next cycle, no reply, IDLE.

Source files
------------

// File: rtl/csoc_scan_ctrl.sv
// rtl/csoc_scan_ctrl.sv - UART byte-command engine driving CSoC reset, test mode and 8-chain scan pins
module csoc_scan_ctrl #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_rcv,
    input  logic [7:0] rx_data,
    input  logic       tx_ready,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic       csoc_reset,
    output logic       csoc_test_tm,
    output logic       csoc_test_se,
    output logic       csoc_clk,
    output logic [7:0] csoc_data_o,
    input  logic [7:0] csoc_data_i,
    output logic       overrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARG,
        S_SDATA,
        S_SETUP,
        S_HIGH,
        S_REPLY
    } state_t;

    localparam logic [7:0] OP_NOP     = 8'h00;
    localparam logic [7:0] OP_MODE    = 8'h10;
    localparam logic [7:0] OP_SHIFT   = 8'h20;
    localparam logic [7:0] OP_CAPTURE = 8'h30;
    localparam logic [7:0] OP_STATUS  = 8'h40;
    localparam logic [7:0] REPLY_ERR  = 8'hEE;
    localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);

    state_t     r_state;
    logic [7:0] r_op;
    logic [8:0] r_cnt;
    logic [7:0] r_div;
    logic [7:0] r_sample;

    logic w_last_div;
    logic w_drop;

    assign w_last_div = (r_div == DIV_LAST);
    assign w_drop     = rx_rcv && ((r_state == S_SETUP) || (r_state == S_HIGH) || (r_state == S_REPLY));

    // Gated by tx_ready directly so a start can never coincide with a busy transmitter.
    assign tx_start = (r_state == S_REPLY) && tx_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_op         <= 8'h00;
            r_cnt        <= 9'd0;
            r_div        <= 8'd0;
            r_sample     <= 8'h00;
            tx_data      <= 8'h00;
            csoc_reset   <= 1'b1;
            csoc_test_tm <= 1'b0;
            csoc_test_se <= 1'b0;
            csoc_clk     <= 1'b0;
            csoc_data_o  <= 8'h00;
            overrun      <= 1'b0;
        end else begin
            // Set is written after clear so a simultaneous drop keeps the flag.
            if (tx_start && (r_op == OP_STATUS)) overrun <= 1'b0;
            if (w_drop) overrun <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (rx_rcv) begin
                        r_op <= rx_data;
                        case (rx_data)
                            OP_NOP: begin
                                tx_data <= 8'h00;
                                r_state <= S_REPLY;
                            end
                            OP_MODE, OP_SHIFT, OP_CAPTURE: r_state <= S_ARG;
                            OP_STATUS: begin
                                tx_data <= {5'b0, overrun, csoc_reset, csoc_test_tm};
                                r_state <= S_REPLY;
                            end
                            default: begin
                                tx_data <= REPLY_ERR;
                                r_state <= S_REPLY;
                            end
                        endcase
                    end
                end
                S_ARG: begin
                    if (rx_rcv) begin
                        if (r_op == OP_MODE) begin
                            csoc_test_tm <= rx_data[0];
                            csoc_reset   <= rx_data[1];
                            tx_data      <= OP_MODE;
                            r_state      <= S_REPLY;
                        end else begin
                            r_cnt <= (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
                            if (r_op == OP_SHIFT) begin
                                r_state <= S_SDATA;
                            end else begin
                                csoc_test_se <= 1'b0;
                                r_div        <= 8'd0;
                                r_state      <= S_SETUP;
                            end
                        end
                    end
                end
                S_SDATA: begin
                    if (rx_rcv) begin
                        csoc_data_o  <= rx_data;
                        csoc_test_se <= 1'b1;
                        r_div        <= 8'd0;
                        r_state      <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (w_last_div) begin
                        r_sample <= csoc_data_i;
                        csoc_clk <= 1'b1;
                        r_div    <= 8'd0;
                        r_state  <= S_HIGH;
                    end else begin
                        r_div <= r_div + 8'd1;
                    end
                end
                S_HIGH: begin
                    if (w_last_div) begin
                        csoc_clk <= 1'b0;
                        r_div    <= 8'd0;
                        if (r_op == OP_SHIFT) begin
                            tx_data <= r_sample;
                            r_state <= S_REPLY;
                        end else if (r_cnt == 9'd1) begin
                            tx_data <= OP_CAPTURE;
                            r_state <= S_REPLY;
                        end else begin
                            r_cnt   <= r_cnt - 9'd1;
                            r_state <= S_SETUP;
                        end
                    end else begin
                        r_div <= r_div + 8'd1;
                    end
                end
                S_REPLY: begin
                    if (tx_ready) begin
                        if (r_op == OP_SHIFT) begin
                            if (r_cnt == 9'd1) begin
                                csoc_test_se <= 1'b0;
                                r_state      <= S_IDLE;
                            end else begin
                                r_cnt   <= r_cnt - 9'd1;
                                r_state <= S_SDATA;
                            end
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_csoc_scan_ctrl.sv
// tb/tb_csoc_scan_ctrl.sv - scoreboard bench for csoc_scan_ctrl
module tb_csoc_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_rcv = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       tx_ready = 1'b1;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       csoc_reset;
    logic       csoc_test_tm;
    logic       csoc_test_se;
    logic       csoc_clk;
    logic [7:0] csoc_data_o;
    logic [7:0] csoc_data_i = 8'h00;
    logic       overrun;

    int checks = 0;
    int errors = 0;
    int starts = 0;
    int pulses = 0;
    logic se_seen = 1'b0;
    logic prev_clk = 1'b0;
    logic [7:0] exp_q[$];

    csoc_scan_ctrl #(.CLK_DIV(4)) dut (
        .clk(clk), .rst(rst), .rx_rcv(rx_rcv), .rx_data(rx_data),
        .tx_ready(tx_ready), .tx_start(tx_start), .tx_data(tx_data),
        .csoc_reset(csoc_reset), .csoc_test_tm(csoc_test_tm), .csoc_test_se(csoc_test_se),
        .csoc_clk(csoc_clk), .csoc_data_o(csoc_data_o), .csoc_data_i(csoc_data_i),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (csoc_clk && !prev_clk) begin
                pulses++;
                if (csoc_test_se) se_seen = 1'b1;
            end
            prev_clk = csoc_clk;
            if (tx_start) begin
                starts++;
                checks++;
                if (tx_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL tx_start_while_busy: tx_ready=%b required 1", tx_ready);
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_reply: got %02h, required no reply", tx_data);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (tx_data !== e) begin
                        errors++;
                        $display("FAIL reply_byte: got %02h required %02h", tx_data, e);
                    end
                end
            end
        end else begin
            prev_clk = 1'b0;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_rcv  = 1'b1;
        rx_data = b;
        @(negedge clk);
        rx_rcv  = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: %0d replies outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({csoc_reset, csoc_test_tm, csoc_test_se, csoc_clk, csoc_data_o, tx_start, tx_data, overrun}
            !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL reset_values: rst=%b tm=%b se=%b clk=%b do=%02h start=%b txd=%02h ovr=%b required 1 0 0 0 00 0 00 0",
                     csoc_reset, csoc_test_tm, csoc_test_se, csoc_clk, csoc_data_o, tx_start, tx_data, overrun);
        end
        rst = 1'b0;
        exp_q.push_back(8'h00);
        send_byte(8'h00);
        wait_drain("nop", 50);
    endtask

    task automatic test_mode;
        exp_q.push_back(8'h10);
        send_byte(8'h10);
        send_byte(8'h03);
        checks++;
        if ({csoc_test_tm, csoc_reset} !== 2'b11) begin
            errors++;
            $display("FAIL mode_03: tm=%b reset=%b required 1 1", csoc_test_tm, csoc_reset);
        end
        wait_drain("mode_03", 50);
        exp_q.push_back(8'h10);
        send_byte(8'h10);
        send_byte(8'h00);
        checks++;
        if ({csoc_test_tm, csoc_reset} !== 2'b00) begin
            errors++;
            $display("FAIL mode_00: tm=%b reset=%b required 0 0", csoc_test_tm, csoc_reset);
        end
        wait_drain("mode_00", 50);
    endtask

    task automatic shift_byte(input logic [7:0] din, input logic [7:0] sample);
        int lo;
        int hi;
        csoc_data_i = sample;
        exp_q.push_back(sample);
        send_byte(din);
        checks++;
        if (csoc_data_o !== din || csoc_test_se !== 1'b1) begin
            errors++;
            $display("FAIL shift_data_o: data_o=%02h se=%b required %02h 1", csoc_data_o, csoc_test_se, din);
        end
        lo = 0;
        while (csoc_clk === 1'b0 && lo < 100) begin
            lo++;
            @(negedge clk);
        end
        csoc_data_i = ~sample;
        hi = 0;
        while (csoc_clk === 1'b1 && hi < 100) begin
            hi++;
            @(negedge clk);
        end
        checks++;
        if (lo != 4 || hi != 4) begin
            errors++;
            $display("FAIL shift_clk_phases: low=%0d high=%0d required 4 4", lo, hi);
        end
        wait_drain("shift", 100);
    endtask

    task automatic test_shift;
        send_byte(8'h20);
        send_byte(8'h02);
        shift_byte(8'hA5, 8'h5A);
        shift_byte(8'h3C, 8'hC3);
        checks++;
        if (csoc_test_se !== 1'b0) begin
            errors++;
            $display("FAIL shift_se_end: se=%b required 0", csoc_test_se);
        end
    endtask

    task automatic run_capture(input logic [7:0] m, input int expect_pulses);
        pulses  = 0;
        se_seen = 1'b0;
        exp_q.push_back(8'h30);
        send_byte(8'h30);
        send_byte(m);
        wait_drain("capture", 6000);
        checks++;
        if (pulses != expect_pulses || se_seen !== 1'b0) begin
            errors++;
            $display("FAIL capture_%02h: pulses=%0d se_seen=%b required %0d 0", m, pulses, se_seen, expect_pulses);
        end
    endtask

    task automatic test_capture;
        run_capture(8'h03, 3);
        run_capture(8'h00, 256);
    endtask

    task automatic test_back_pressure;
        int s0;
        logic bad;
        tx_ready = 1'b0;
        exp_q.push_back(8'hEE);
        send_byte(8'h55);
        s0  = starts;
        bad = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (tx_start !== 1'b0 || tx_data !== 8'hEE) bad = 1'b1;
        end
        checks++;
        if (bad || starts != s0) begin
            errors++;
            $display("FAIL backpressure_hold: start_seen=%0d data_bad=%b required 0 0", starts - s0, bad);
        end
        tx_ready = 1'b1;
        wait_drain("backpressure", 20);
        repeat (5) @(negedge clk);
        checks++;
        if (starts != s0 + 1) begin
            errors++;
            $display("FAIL backpressure_pulses: got %0d starts required 1", starts - s0);
        end
    endtask

    task automatic test_overrun_status;
        int n;
        csoc_data_i = 8'h6B;
        exp_q.push_back(8'h6B);
        send_byte(8'h20);
        send_byte(8'h01);
        send_byte(8'h11);
        n = 0;
        while (csoc_clk !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        send_byte(8'h99);
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_set: overrun=%b required 1", overrun);
        end
        wait_drain("overrun_shift", 100);
        exp_q.push_back(8'h04);
        send_byte(8'h40);
        wait_drain("status", 50);
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun_clear: overrun=%b required 0", overrun);
        end
    endtask

    task automatic test_unknown_and_abort;
        int n;
        int s0;
        exp_q.push_back(8'hEE);
        send_byte(8'h7F);
        wait_drain("unknown", 50);
        send_byte(8'h20);
        send_byte(8'h01);
        send_byte(8'h77);
        n = 0;
        while (csoc_clk !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        s0  = starts;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({csoc_reset, csoc_test_tm, csoc_test_se, csoc_clk, csoc_data_o, tx_start, tx_data, overrun}
            !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL abort_reset: rst=%b tm=%b se=%b clk=%b do=%02h start=%b txd=%02h ovr=%b required 1 0 0 0 00 0 00 0",
                     csoc_reset, csoc_test_tm, csoc_test_se, csoc_clk, csoc_data_o, tx_start, tx_data, overrun);
        end
        rst = 1'b0;
        repeat (20) @(negedge clk);
        checks++;
        if (starts != s0) begin
            errors++;
            $display("FAIL abort_no_reply: got %0d replies required 0", starts - s0);
        end
        exp_q.push_back(8'h00);
        send_byte(8'h00);
        wait_drain("post_abort_nop", 50);
    endtask

    initial begin
        test_reset();
        test_mode();
        test_shift();
        test_capture();
        test_back_pressure();
        test_overrun_status();
        test_unknown_and_abort();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_empty: %0d left required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
